// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
//   Shared definitions for the traffic light controller:
//   - phase codes (2'd3 is illegal and is treated as RED)
//   - one-hot LED patterns, led[2]=red, led[1]=yellow, led[0]=green
//   - helpers that map a phase to its LED pattern and to its successor phase
// -----------------------------------------------------------------------------
package tl_pkg;

  typedef enum logic [1:0] {
    PH_RED     = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_ILLEGAL = 2'd3
  } phase_e;

  localparam logic [2:0] LED_RED = 3'b100;
  localparam logic [2:0] LED_YEL = 3'b010;
  localparam logic [2:0] LED_GRN = 3'b001;

  // One-hot LED pattern for a phase; anything unexpected shows RED.
  function automatic logic [2:0] phase_to_led(input phase_e ph);
    logic [2:0] led_v;
    case (ph)
      PH_GREEN:  led_v = LED_GRN;
      PH_YELLOW: led_v = LED_YEL;
      default:   led_v = LED_RED;
    endcase
    return led_v;
  endfunction

  // RED -> GREEN -> YELLOW -> RED; the illegal code recovers into RED.
  function automatic phase_e next_phase(input phase_e ph);
    phase_e nxt_v;
    case (ph)
      PH_RED:    nxt_v = PH_GREEN;
      PH_GREEN:  nxt_v = PH_YELLOW;
      PH_YELLOW: nxt_v = PH_RED;
      default:   nxt_v = PH_RED;
    endcase
    return nxt_v;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides clk into a one-cycle tick every TICK_DIV enabled cycles.
//   Ports:
//     clk     in  system clock
//     reset   in  asynchronous reset, active-high (count returns to 0)
//     enable  in  1 = count, 0 = hold the count and suppress tick
//     tick    out high for one cycle when count==TICK_DIV-1 and enable=1
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          at_last_s;

  // Next count and tick; a disabled cycle holds the count even at LAST.
  always_comb begin
    at_last_s = (count_q == LAST);
    tick      = enable & at_last_s;
    count_d   = count_q;
    if (enable) begin
      if (at_last_s) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//   Sequences a 3-LED light RED -> GREEN -> YELLOW -> RED, each phase lasting a
//   per-phase number of prescaler ticks.
//   Optional feature macro: PED_REQ_EN (pedestrian request shortens GREEN).
//   Ports:
//     clk       in   system clock
//     reset     in   asynchronous reset, active-high
//     enable    in   1 = run, 0 = freeze prescaler, counter and phase
//     ped_req   in   pedestrian request pulse (only with PED_REQ_EN)
//     led       out  [2]=red [1]=yellow [0]=green, one-hot, registered
//     phase     out  current phase code (tl_pkg), registered
//     sec_left  out  ticks remaining in the phase minus 1, registered
// -----------------------------------------------------------------------------
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned RED_S    = 5,
  parameter int unsigned GREEN_S  = 5,
  parameter int unsigned YELLOW_S = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
`ifdef PED_REQ_EN
  input  logic             ped_req,
`endif
  output logic [2:0]       led,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] sec_left
);

  // Durations must fit the counter as DUR-1, so sec_left can never wrap.
  if ((RED_S < 1) || (RED_S > (2 ** CNT_W))) begin : g_bad_red
    $error("traffic_light_ctrl: RED_S=%0d outside 1..2**CNT_W", RED_S);
  end
  if ((GREEN_S < 1) || (GREEN_S > (2 ** CNT_W))) begin : g_bad_green
    $error("traffic_light_ctrl: GREEN_S=%0d outside 1..2**CNT_W", GREEN_S);
  end
  if ((YELLOW_S < 1) || (YELLOW_S > (2 ** CNT_W))) begin : g_bad_yellow
    $error("traffic_light_ctrl: YELLOW_S=%0d outside 1..2**CNT_W", YELLOW_S);
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("traffic_light_ctrl: TICK_DIV must be at least 1");
  end

  localparam logic [CNT_W-1:0] RED_LD = CNT_W'(RED_S - 1);
  localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GREEN_S - 1);
  localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YELLOW_S - 1);
  localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // Reload value for the phase being entered.
  function automatic logic [CNT_W-1:0] phase_load(input phase_e ph);
    logic [CNT_W-1:0] ld_v;
    case (ph)
      PH_GREEN:  ld_v = GRN_LD;
      PH_YELLOW: ld_v = YEL_LD;
      default:   ld_v = RED_LD;
    endcase
    return ld_v;
  endfunction

  logic             tick_s;
  logic             shorten_s;
  phase_e           phase_q;
  phase_e           phase_d;
  logic [CNT_W-1:0] sec_q;
  logic [CNT_W-1:0] sec_d;
  logic [2:0]       led_q;
  logic [2:0]       led_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick_s)
  );

`ifdef PED_REQ_EN
  logic ped_pending_q;
  logic ped_pending_d;
  logic enter_red_s;

  // Sticky pedestrian flag; entering RED clears it even if a request coincides.
  always_comb begin
    enter_red_s   = tick_s && (sec_q == ZERO) && (next_phase(phase_q) == PH_RED);
    shorten_s     = ped_pending_q && (phase_q == PH_GREEN);
    ped_pending_d = ped_pending_q;
    if (enter_red_s) begin
      ped_pending_d = 1'b0;
    end else begin
      ped_pending_d = ped_pending_q | ped_req;
    end
  end

  // Pedestrian flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pending_q <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
    end
  end
`else
  assign shorten_s = 1'b0;
`endif

  // Phase FSM and seconds counter; LED is decoded from the next phase so the
  // registered LED changes on the same edge as the phase.
  always_comb begin
    phase_d = phase_q;
    sec_d   = sec_q;
    led_d   = led_q;
    if (tick_s) begin
      if (sec_q == ZERO) begin
        phase_d = next_phase(phase_q);
        sec_d   = phase_load(phase_d);
        led_d   = phase_to_led(phase_d);
      end else if (shorten_s) begin
        sec_d = ZERO;
      end else begin
        sec_d = sec_q - ONE;
      end
    end else begin
      sec_d = sec_q;
    end
  end

  // Phase, counter and LED registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_RED;
      sec_q   <= RED_LD;
      led_q   <= LED_RED;
    end else begin
      phase_q <= phase_d;
      sec_q   <= sec_d;
      led_q   <= led_d;
    end
  end

  assign led      = led_q;
  assign phase    = phase_q;
  assign sec_left = sec_q;

endmodule
